// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, reset PC default and fetch entry type
package inst_fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO with synchronous flush
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch PC, credit-based request issue and redirect handling
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int OCC_W = CW + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic             drop_q, drop_d;
    logic [CW-1:0]    count;
    logic [OCC_W-1:0] occupancy;
    logic             pop_raw, pop, push, accept;
    fetch_entry_t     push_entry, head_entry;

    always_comb begin
        pop_raw   = out_valid && out_ready;
        // Entries held plus the one on its way back, less the one leaving now.
        occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_raw};
        imem_req  = !rst && !redirect && (occupancy < OCC_W'(DEPTH));
        accept    = imem_req && imem_ready;
        pop       = pop_raw && !redirect;
        push      = imem_rvalid && inflight_q && !drop_q;

        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = accept;
        drop_d     = drop_q && !imem_rvalid;
        if (redirect) begin
            fetch_pc_d = align_pc(redirect_pc);
            // A response landing this cycle is removed by the flush itself.
            drop_d     = inflight_q && !imem_rvalid;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            req_pc_d   = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    assign push_entry = '{pc: req_pc_q, inst: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head_data (head_entry)
    );

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count != '0);
    assign out_inst  = head_entry.inst;
    assign out_pc    = head_entry.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed and randomized checks of inst_fetch against a queue model
module tb_inst_fetch;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;
    localparam logic [31:0] SALT  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_ready, imem_rvalid, redirect, out_valid, out_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_inst, out_pc;

    inst_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: next fetch address, pc whose response arrives this cycle, queue of buffered pcs.
    logic [31:0] m_fetch = RPC;
    bit          m_infl  = 1'b0;
    logic [31:0] m_infl_pc;
    logic [31:0] m_q[$];

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit          e_req, pop, acc;
        int          occ;
        logic [31:0] acc_addr;
        @(negedge clk);
        pop   = (m_q.size() != 0) && out_ready;
        occ   = m_q.size() + int'(m_infl) - int'(pop);
        e_req = !rst && !redirect && (occ < DEPTH);
        check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        if (e_req) check("imem_addr", imem_addr, m_fetch);
        check("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            check("out_pc", out_pc, m_q[0]);
            check("out_inst", out_inst, m_q[0] ^ SALT);
        end
        s_req = imem_req; s_addr = imem_addr; s_valid = out_valid; s_pc = out_pc;
        acc = imem_req && imem_ready;
        acc_addr = imem_addr;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_fetch = RPC;
            m_infl  = 1'b0;
        end else if (redirect) begin
            m_q.delete();
            m_fetch = {redirect_pc[31:2], 2'b00};
            m_infl  = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_pc);
            check("no_overflow", {31'b0, m_q.size() <= DEPTH}, 32'd1);
            m_infl = e_req && imem_ready;
            if (m_infl) begin
                m_infl_pc = m_fetch;
                m_fetch   = m_fetch + 32'd4;
            end
        end
        #1;
        imem_rvalid = acc;
        imem_rdata  = acc ? (acc_addr ^ SALT) : 32'hDEAD_BEEF;
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; out_ready = 1'b1; redirect = 1'b0;
        redirect_pc = '0; imem_rvalid = 1'b0; imem_rdata = '0;
        step();
        step();
        check("rst_req", {31'b0, s_req}, 32'd0);
        check("rst_valid", {31'b0, s_valid}, 32'd0);

        // Streaming after reset release
        rst = 1'b0;
        step();
        check("first_addr", s_addr, RPC);
        step();
        check("valid_t1", {31'b0, s_valid}, 32'd0);
        step();
        check("first_pc", s_pc, RPC);
        repeat (5) step();

        // Backpressure
        out_ready = 1'b0;
        repeat (6) step();
        check("bp_req_low", {31'b0, s_req}, 32'd0);
        check("bp_valid", {31'b0, s_valid}, 32'd1);
        out_ready = 1'b1;
        repeat (4) step();

        // Redirect while a response is on its way back
        begin
            int guard = 0;
            while (!m_infl && guard < 20) begin
                step();
                guard++;
            end
            check("infl_found", {31'b0, m_infl}, 32'd1);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_2003;
        step();
        redirect = 1'b0;
        step();
        check("redir_addr", s_addr, 32'h0000_2000);
        check("redir_v1", {31'b0, s_valid}, 32'd0);
        step();
        check("redir_v2", {31'b0, s_valid}, 32'd0);
        step();
        check("redir_pc", s_pc, 32'h0000_2000);
        repeat (3) step();

        // imem_ready stalls
        imem_ready = 1'b1; step();
        imem_ready = 1'b0; step(); step();
        imem_ready = 1'b1; repeat (4) step();

        // Address wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        step(); step(); step();
        check("wrap_pc0", s_pc, 32'hFFFF_FFF8);
        step();
        check("wrap_pc1", s_pc, 32'hFFFF_FFFC);
        step();
        check("wrap_pc2", s_pc, 32'h0000_0000);

        // Randomized traffic with occasional redirects
        for (int i = 0; i < 400; i++) begin
            imem_ready  = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom();
            step();
        end
        redirect = 1'b0; imem_ready = 1'b1;

        // Reset in the middle of a full stream
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("mrst_valid", {31'b0, s_valid}, 32'd0);
        check("mrst_addr", s_addr, RPC);
        step();
        step();
        check("mrst_pc", s_pc, RPC);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
